// File: rtl/count_sequencer.sv
// Command-driven counter controller: prescaled WIDTH-bit count up to a programmable
// terminal value, one-shot or auto-reload, with registered terminal-count pulse.
module count_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             cmd_ready,
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic             tc,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] OP_SETMAX = 2'b00;
  localparam logic [1:0] OP_ONESHOT = 2'b01;
  localparam logic [1:0] OP_RELOAD = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             accept, tick;

  assign cmd_ready = (state_q != RUN) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (pre_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      max_q    <= '1;
      pre_q    <= '0;
      reload_q <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      max_q    <= max_d;
      pre_q    <= pre_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    max_d    = max_q;
    pre_d    = pre_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    case (state_q)
      RUN: begin
        // Only STOP can be accepted here, and it pre-empts a coincident tick.
        if (accept) begin
          state_d = IDLE;
          pre_d   = '0;
        end else begin
          pre_d = tick ? '0 : pre_q + PW'(1);
          if (tick) begin
            if (q_q == max_q) begin
              tc_d = 1'b1;
              if (reload_q) q_d = '0;
              else          state_d = DONE;
            end else begin
              q_d = q_q + WIDTH'(1);
            end
          end
        end
      end
      default: begin
        if (accept) begin
          case (cmd_op)
            OP_SETMAX: begin
              max_d   = cmd_data;
              state_d = IDLE;
            end
            OP_ONESHOT, OP_RELOAD: begin
              q_d      = '0;
              pre_d    = '0;
              reload_d = (cmd_op == OP_RELOAD);
              state_d  = RUN;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  assign q       = q_q;
  assign tc      = tc_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule
